fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/HALT controller.
// Redirects, stalls and halts are resolved each cycle. Every output comes straight from a flop.
module fetch_unit #(
   parameter int unsigned PC_W     = 9,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic            Stall,
   input  logic            Halt,
   input  logic [31:0]     Inst_in,
   output logic [PC_W-1:0] Cur_PC,
   output logic [PC_W-1:0] IfId_PC,
   output logic [31:0]     IfId_Inst,
   output logic            IfId_Valid,
   output logic            Halted,
   output logic            Misaligned,
   output logic [31:0]     FetchCount,
   output logic [15:0]     FlushCount
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]     ifid_inst_q, ifid_inst_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic            halted_q, halted_d;
   logic            misaligned_q, misaligned_d;
   logic [31:0]     fetch_cnt_q, fetch_cnt_d;
   logic [15:0]     flush_cnt_q, flush_cnt_d;

   // Only the low PC_W bits of the redirect target address instruction memory.
   logic unused_brpc;
   assign unused_brpc = ^BrPC[31:PC_W];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_valid_d = ifid_valid_q;
      halted_d     = 1'b0;
      misaligned_d = 1'b0;
      fetch_cnt_d  = fetch_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      unique case (state_q)
         StBoot: begin
            pc_d         = '0;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            state_d      = StRun;
         end
         StRun: begin
            if (Halt) begin
               state_d      = StHalt;
               halted_d     = 1'b1;
               ifid_pc_d    = pc_q;
               ifid_inst_d  = NOP_INST;
               ifid_valid_d = 1'b0;
            end else if (PcSel) begin
               // A redirect squashes the wrong-path fetch even when a stall is pending.
               pc_d         = {BrPC[PC_W-1:2], 2'b00};
               misaligned_d = |BrPC[1:0];
               flush_cnt_d  = flush_cnt_q + 16'd1;
               ifid_pc_d    = pc_q;
               ifid_inst_d  = NOP_INST;
               ifid_valid_d = 1'b0;
            end else if (!Stall) begin
               pc_d         = pc_q + PC_W'(4);
               ifid_pc_d    = pc_q;
               ifid_inst_d  = Inst_in;
               ifid_valid_d = 1'b1;
               fetch_cnt_d  = fetch_cnt_q + 32'd1;
            end
         end
         StHalt: begin
            halted_d     = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StBoot;
         pc_q         <= '0;
         ifid_pc_q    <= '0;
         ifid_inst_q  <= NOP_INST;
         ifid_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         misaligned_q <= 1'b0;
         fetch_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_valid_q <= ifid_valid_d;
         halted_q     <= halted_d;
         misaligned_q <= misaligned_d;
         fetch_cnt_q  <= fetch_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign Cur_PC     = pc_q;
   assign IfId_PC    = ifid_pc_q;
   assign IfId_Inst  = ifid_inst_q;
   assign IfId_Valid = ifid_valid_q;
   assign Halted     = halted_q;
   assign Misaligned = misaligned_q;
   assign FetchCount = fetch_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with PC_W=9.
module tb_fetch_unit;

   localparam int unsigned PC_W = 9;
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] ADDI = 32'h00A00093;

   logic            clk = 1'b0;
   logic            reset;
   logic            PcSel;
   logic [31:0]     BrPC;
   logic            Stall;
   logic            Halt;
   logic [31:0]     Inst_in;
   logic [PC_W-1:0] Cur_PC;
   logic [PC_W-1:0] IfId_PC;
   logic [31:0]     IfId_Inst;
   logic            IfId_Valid;
   logic            Halted;
   logic            Misaligned;
   logic [31:0]     FetchCount;
   logic [15:0]     FlushCount;

   int total = 0;
   int bad   = 0;

   fetch_unit #(.PC_W(PC_W), .NOP_INST(NOP)) dut (
      .clk        (clk),
      .reset      (reset),
      .PcSel      (PcSel),
      .BrPC       (BrPC),
      .Stall      (Stall),
      .Halt       (Halt),
      .Inst_in    (Inst_in),
      .Cur_PC     (Cur_PC),
      .IfId_PC    (IfId_PC),
      .IfId_Inst  (IfId_Inst),
      .IfId_Valid (IfId_Valid),
      .Halted     (Halted),
      .Misaligned (Misaligned),
      .FetchCount (FetchCount),
      .FlushCount (FlushCount)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ifpc,
                            input logic [31:0] inst, input logic valid, input logic halted,
                            input logic mis, input logic [31:0] fc, input logic [31:0] flc);
      check({tag, ".Cur_PC"},     32'(Cur_PC),     pc);
      check({tag, ".IfId_PC"},    32'(IfId_PC),    ifpc);
      check({tag, ".IfId_Inst"},  IfId_Inst,       inst);
      check({tag, ".IfId_Valid"}, 32'(IfId_Valid), 32'(valid));
      check({tag, ".Halted"},     32'(Halted),     32'(halted));
      check({tag, ".Misaligned"}, 32'(Misaligned), 32'(mis));
      check({tag, ".FetchCount"}, FetchCount,      fc);
      check({tag, ".FlushCount"}, 32'(FlushCount), flc);
   endtask

   initial begin
      reset = 1'b1; PcSel = 1'b0; BrPC = '0; Stall = 1'b0; Halt = 1'b0; Inst_in = ADDI;
      step();
      check_all("reset", 0, 0, NOP, 0, 0, 0, 0, 0);

      // BOOT cycle: bubble at PC 0
      reset = 1'b0;
      step();
      check_all("boot", 0, 0, NOP, 0, 0, 0, 0, 0);

      step();
      check_all("run0", 32'h4, 32'h0, ADDI, 1, 0, 0, 1, 0);
      step();
      check_all("run1", 32'h8, 32'h4, ADDI, 1, 0, 0, 2, 0);
      step();
      step();
      check_all("run3", 32'h10, 32'hC, ADDI, 1, 0, 0, 4, 0);

      // Three stall cycles; changing Inst_in must not leak into IF/ID
      Stall = 1'b1; Inst_in = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("stall", 32'h10, 32'hC, ADDI, 1, 0, 0, 4, 0);
      end

      // Redirect overrides stall
      PcSel = 1'b1; BrPC = 32'h40;
      step();
      check_all("redir_stall", 32'h40, 32'h10, NOP, 0, 0, 0, 4, 1);

      PcSel = 1'b0; Stall = 1'b0; Inst_in = 32'h11111111;
      step();
      check_all("after_redir", 32'h44, 32'h40, 32'h11111111, 1, 0, 0, 5, 1);

      // Misaligned redirect: low bits cleared, one-cycle pulse
      PcSel = 1'b1; BrPC = 32'h46;
      step();
      check_all("misalign", 32'h44, 32'h44, NOP, 0, 0, 1, 5, 2);
      PcSel = 1'b0;
      step();
      check_all("mis_clear", 32'h48, 32'h44, 32'h11111111, 1, 0, 0, 6, 2);

      // Upper target bits are ignored; then PC wraps 0x1FC -> 0x000
      PcSel = 1'b1; BrPC = 32'hFFFFFFF8;
      step();
      check_all("redir_hi", 32'h1F8, 32'h48, NOP, 0, 0, 0, 6, 3);
      PcSel = 1'b0; Inst_in = 32'h22222222;
      step();
      check_all("pre_wrap", 32'h1FC, 32'h1F8, 32'h22222222, 1, 0, 0, 7, 3);
      step();
      check_all("wrap", 32'h0, 32'h1FC, 32'h22222222, 1, 0, 0, 8, 3);

      // Halt beats redirect
      Halt = 1'b1; PcSel = 1'b1; BrPC = 32'h80;
      step();
      check_all("halt", 32'h0, 32'h0, NOP, 0, 1, 0, 8, 3);

      Halt = 1'b0; Stall = 1'b0;
      step();
      check_all("halt_hold", 32'h0, 32'h0, NOP, 0, 1, 0, 8, 3);

      // Reset from HALT with a redirect pending
      reset = 1'b1;
      step();
      check_all("reset2", 0, 0, NOP, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
